// File: rtl/pwm_dac_if.sv
// rtl/pwm_dac_if.sv - run/sample inputs and PWM drive outputs of pwm_dac
interface pwm_dac_if #(
    parameter int RES = 10
);
    logic           en;
    logic [15:0]    sample;
    logic           pwm_p;
    logic           pwm_n;
    logic           frame;
    logic [RES-1:0] duty;

    modport master (
        output en, sample,
        input  pwm_p, pwm_n, frame, duty
    );

    modport slave (
        input  en, sample,
        output pwm_p, pwm_n, frame, duty
    );
endinterface

// File: rtl/pwm_dac.sv
// rtl/pwm_dac.sv - PWM DAC with complementary outputs and dead-time insertion
module pwm_dac #(
    parameter int RES  = 10,
    parameter int DEAD = 2
) (
    input  logic       clk,
    input  logic       rst,
    pwm_dac_if.slave   bus
);
    localparam int DW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
    localparam logic [RES-1:0] CNT_MAX   = '1;
    localparam logic [DW-1:0]  DEAD_INIT = DW'(DEAD);
    localparam logic [DW-1:0]  DEAD_RELOAD = (DEAD > 0) ? DW'(DEAD - 1) : '0;

    typedef enum logic {IDLE, RUN} state_e;

    state_e         state_q, state_d;
    logic [RES-1:0] cnt_q, cnt_d;
    logic [RES-1:0] duty_q, duty_d;
    logic [DW-1:0]  dead_q, dead_d;
    logic           raw_last_q, raw_last_d;
    logic           pwm_p_q, pwm_p_d;
    logic           pwm_n_q, pwm_n_d;
    logic [15:0]    offset;
    logic [RES-1:0] duty_conv;
    logic           raw;

    // Signed sample to offset binary, then keep the top RES bits (truncation).
    always_comb begin
        offset    = {~bus.sample[15], bus.sample[14:0]};
        duty_conv = RES'(offset >> (16 - RES));
    end

    assign raw = (state_q == RUN) && (cnt_q < duty_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        duty_d     = duty_q;
        dead_d     = dead_q;
        raw_last_d = 1'b0;
        pwm_p_d    = 1'b0;
        pwm_n_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                dead_d = '0;
                if (bus.en) begin
                    state_d = RUN;
                    duty_d  = duty_conv;
                    // Entry behaves like a raw edge: a full dead window precedes either drive.
                    dead_d  = DEAD_INIT;
                end
            end
            RUN: begin
                cnt_d      = cnt_q + 1'b1;
                raw_last_d = raw;
                if (cnt_q == CNT_MAX) begin
                    if (bus.en) begin
                        duty_d = duty_conv;
                    end else begin
                        state_d = IDLE;
                    end
                end
                if (DEAD == 0) begin
                    pwm_p_d = raw;
                    pwm_n_d = ~raw;
                end else if (raw != raw_last_q) begin
                    dead_d = DEAD_RELOAD;
                end else if (dead_q != '0) begin
                    dead_d = dead_q - 1'b1;
                end else begin
                    pwm_p_d = raw;
                    pwm_n_d = ~raw;
                end
                if (state_d == IDLE) begin
                    pwm_p_d = 1'b0;
                    pwm_n_d = 1'b0;
                    dead_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            duty_q     <= '0;
            dead_q     <= '0;
            raw_last_q <= 1'b0;
            pwm_p_q    <= 1'b0;
            pwm_n_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            dead_q     <= dead_d;
            raw_last_q <= raw_last_d;
            pwm_p_q    <= pwm_p_d;
            pwm_n_q    <= pwm_n_d;
        end
    end

    assign bus.pwm_p = pwm_p_q;
    assign bus.pwm_n = pwm_n_q;
    assign bus.frame = (state_q == RUN) && (cnt_q == '0);
    assign bus.duty  = duty_q;
endmodule
